// File: rtl/psum_writeback.sv
// Packs per-kernel psum bytes into words, queues them in a FIFO and streams them out
// as sequential BRAM write commands for a programmed word count.
module psum_writeback #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_STEP  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BIT_WIDTH*NUM_KERNEL-1:0] i_psum,
  input  logic [NUM_KERNEL-1:0]           i_psum_val,
  input  logic                            i_start,
  input  logic [ADDR_WIDTH-1:0]           i_base_addr,
  input  logic [31:0]                     i_cnt,
  input  logic                            i_stall,
  output logic [ADDR_WIDTH-1:0]           o_addr,
  output logic [DATA_WIDTH-1:0]           o_wdata,
  output logic                            o_wren,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_C = ADDR_WIDTH'(ADDR_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [BIT_WIDTH-1:0]    hold_r [NUM_KERNEL];
  logic [NUM_KERNEL-1:0]   pend_r;
  logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_r;
  logic [AW-1:0]           rd_ptr_r;
  logic [AW:0]             count_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [31:0]             remaining_r;
  logic                    overflow_r;
  logic                    wren_r;
  logic                    done_r;
  logic [ADDR_WIDTH-1:0]   out_addr_r;
  logic [DATA_WIDTH-1:0]   out_wdata_r;

  logic [DATA_WIDTH-1:0]   word_s;
  logic                    complete_s;
  logic                    collision_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic                    pop_s;
  logic                    push_s;
  logic                    drop_s;
  logic                    start_s;

  assign complete_s   = &(pend_r | i_psum_val);
  assign collision_s  = |(pend_r & i_psum_val);
  assign fifo_full_s  = (count_r == DEPTH_C);
  assign fifo_empty_s = (count_r == {(AW+1){1'b0}});
  assign start_s      = (state_r == IDLE) && i_start;
  assign pop_s        = (state_r == RUN) && !fifo_empty_s && !i_stall && (remaining_r != 32'd0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign push_s       = complete_s && (!fifo_full_s || pop_s);
  assign drop_s       = complete_s && fifo_full_s && !pop_s;

  // Assemble the completing word: pending lanes keep their held byte, others take the live byte.
  always_comb begin
    word_s = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < NUM_KERNEL; k++) begin
      if (pend_r[k]) begin
        word_s[k*BIT_WIDTH +: BIT_WIDTH] = hold_r[k];
      end else begin
        word_s[k*BIT_WIDTH +: BIT_WIDTH] = i_psum[k*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Per-lane holding registers and pending flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r <= {NUM_KERNEL{1'b0}};
      for (int k = 0; k < NUM_KERNEL; k++) begin
        hold_r[k] <= {BIT_WIDTH{1'b0}};
      end
    end else if (complete_s) begin
      pend_r <= {NUM_KERNEL{1'b0}};
    end else begin
      for (int k = 0; k < NUM_KERNEL; k++) begin
        if (i_psum_val[k] && !pend_r[k]) begin
          hold_r[k] <= i_psum[k*BIT_WIDTH +: BIT_WIDTH];
          pend_r[k] <= 1'b1;
        end
      end
    end
  end

  // Sticky overflow; a new run clears it unless an error lands in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else if (collision_s || drop_s) begin
      overflow_r <= 1'b1;
    end else if (start_s) begin
      overflow_r <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Write FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          state_s = (i_cnt == 32'd0) ? DONE : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (pop_s && (remaining_r == 32'd1)) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Run address and remaining-word counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r      <= {ADDR_WIDTH{1'b0}};
      remaining_r <= 32'd0;
    end else if (start_s) begin
      addr_r      <= i_base_addr;
      remaining_r <= i_cnt;
    end else if (pop_s) begin
      addr_r      <= addr_r + STEP_C;
      remaining_r <= remaining_r - 32'd1;
    end
  end

  // Registered write command; address and data hold between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wren_r      <= 1'b0;
      done_r      <= 1'b0;
      out_addr_r  <= {ADDR_WIDTH{1'b0}};
      out_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      wren_r <= pop_s;
      done_r <= (state_r == DONE);
      if (pop_s) begin
        out_addr_r  <= addr_r;
        out_wdata_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign o_addr     = out_addr_r;
  assign o_wdata    = out_wdata_r;
  assign o_wren     = wren_r;
  assign o_done     = done_r;
  assign o_busy     = (state_r != IDLE);
  assign o_overflow = overflow_r;

endmodule

// File: tb/tb_psum_writeback.sv
// Directed bench for psum_writeback: lane packing, FIFO buffering, stalls, overflow, reset.
module tb_psum_writeback;

  logic        clk;
  logic        rst;
  logic [31:0] i_psum;
  logic [3:0]  i_psum_val;
  logic        i_start;
  logic [31:0] i_base_addr;
  logic [31:0] i_cnt;
  logic        i_stall;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic        o_wren;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;

  int n_checks = 0;
  int n_errors = 0;

  psum_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .i_psum      (i_psum),
    .i_psum_val  (i_psum_val),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_cnt       (i_cnt),
    .i_stall     (i_stall),
    .o_addr      (o_addr),
    .o_wdata     (o_wdata),
    .o_wren      (o_wren),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_overflow  (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_wren"}, {63'd0, o_wren}, 64'd1);
    chk({tag, "_addr"}, {32'd0, o_addr}, {32'd0, addr});
    chk({tag, "_data"}, {32'd0, o_wdata}, {32'd0, data});
  endtask

  task automatic drive(input logic [31:0] p, input logic [3:0] v);
    i_psum     = p;
    i_psum_val = v;
  endtask

  task automatic start_run(input logic [31:0] base, input logic [31:0] cnt);
    i_base_addr = base;
    i_cnt       = cnt;
    i_start     = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit exceeded");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; i_psum = 32'd0; i_psum_val = 4'd0; i_start = 1'b0;
    i_base_addr = 32'd0; i_cnt = 32'd0; i_stall = 1'b0;
    step(); step();
    chk("rst_wren", {63'd0, o_wren}, 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_done", {63'd0, o_done}, 64'd0);
    chk("rst_ovf", {63'd0, o_overflow}, 64'd0);
    chk("rst_addr", {32'd0, o_addr}, 64'd0);
    chk("rst_wdata", {32'd0, o_wdata}, 64'd0);
    rst = 1'b1;
    step();

    // Test 1: three full words, base 0x100, count 3
    start_run(32'h100, 32'd3);
    step();
    i_start = 1'b0;
    chk("t1_busy", {63'd0, o_busy}, 64'd1);
    drive(32'h04030201, 4'hF); step();
    chk("t1_wren_lat", {63'd0, o_wren}, 64'd0);
    drive(32'h08070605, 4'hF); step();
    chk_wr("t1_w0", 32'h100, 32'h04030201);
    drive(32'h0C0B0A09, 4'hF); step();
    drive(32'd0, 4'd0);
    chk_wr("t1_w1", 32'h101, 32'h08070605);
    step();
    chk_wr("t1_w2", 32'h102, 32'h0C0B0A09);
    chk("t1_done_early", {63'd0, o_done}, 64'd0);
    step();
    chk("t1_done", {63'd0, o_done}, 64'd1);
    chk("t1_wren_off", {63'd0, o_wren}, 64'd0);
    chk("t1_idle", {63'd0, o_busy}, 64'd0);
    step();
    chk("t1_done_pulse", {63'd0, o_done}, 64'd0);

    // Test 2: staggered lanes form one word
    start_run(32'h200, 32'd1);
    drive(32'h00000011, 4'b0001); step();
    i_start = 1'b0;
    drive(32'hEEEE22EE, 4'b0010); step();
    drive(32'hEE33EEEE, 4'b0100); step();
    drive(32'h44EEEEEE, 4'b1000); step();
    drive(32'd0, 4'd0);
    chk("t2_wren_t4", {63'd0, o_wren}, 64'd0);
    step();
    chk_wr("t2_w0", 32'h200, 32'h44332211);
    chk("t2_ovf", {63'd0, o_overflow}, 64'd0);
    step();
    chk("t2_done", {63'd0, o_done}, 64'd1);
    step();

    // Test 3: stall for 4 cycles with 3 words queued
    i_stall = 1'b1;
    start_run(32'h300, 32'd3);
    drive(32'hA1A2A3A4, 4'hF); step();
    i_start = 1'b0;
    chk("t3_stall1", {63'd0, o_wren}, 64'd0);
    drive(32'hB1B2B3B4, 4'hF); step();
    chk("t3_stall2", {63'd0, o_wren}, 64'd0);
    drive(32'hC1C2C3C4, 4'hF); step();
    drive(32'd0, 4'd0);
    chk("t3_stall3", {63'd0, o_wren}, 64'd0);
    step();
    chk("t3_stall4", {63'd0, o_wren}, 64'd0);
    i_stall = 1'b0;
    step();
    chk_wr("t3_w0", 32'h300, 32'hA1A2A3A4);
    step();
    chk_wr("t3_w1", 32'h301, 32'hB1B2B3B4);
    step();
    chk_wr("t3_w2", 32'h302, 32'hC1C2C3C4);
    step();
    chk("t3_done", {63'd0, o_done}, 64'd1);
    step();

    // Test 4: nine words into an 8-deep FIFO, then drain eight
    for (int i = 0; i < 8; i++) begin
      drive(32'h10203040 + 32'(i), 4'hF);
      step();
    end
    chk("t4_ovf_full", {63'd0, o_overflow}, 64'd0);
    drive(32'hDEADBEEF, 4'hF); step();
    drive(32'd0, 4'd0);
    chk("t4_ovf_set", {63'd0, o_overflow}, 64'd1);
    start_run(32'h400, 32'd8);
    step();
    i_start = 1'b0;
    chk("t4_ovf_clr", {63'd0, o_overflow}, 64'd0);
    chk("t4_wren_lat", {63'd0, o_wren}, 64'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk_wr($sformatf("t4_w%0d", i), 32'h400 + 32'(i), 32'h10203040 + 32'(i));
      step();
    end
    chk("t4_done", {63'd0, o_done}, 64'd1);
    step();

    // Test 5: lane 0 collision keeps the first byte
    start_run(32'h500, 32'd1);
    drive(32'h000000AA, 4'b0001); step();
    i_start = 1'b0;
    drive(32'h000000BB, 4'b0001); step();
    chk("t5_ovf", {63'd0, o_overflow}, 64'd1);
    drive(32'h112233FF, 4'b1110); step();
    drive(32'd0, 4'd0);
    step();
    chk_wr("t5_w0", 32'h500, 32'h112233AA);
    step();
    chk("t5_done", {63'd0, o_done}, 64'd1);
    step();

    // Test 6: reset after two of five writes
    start_run(32'h600, 32'd5);
    drive(32'h60000000, 4'hF); step();
    i_start = 1'b0;
    drive(32'h60000001, 4'hF); step();
    drive(32'h60000002, 4'hF);
    chk_wr("t6_w0", 32'h600, 32'h60000000);
    step();
    drive(32'h60000003, 4'hF);
    chk_wr("t6_w1", 32'h601, 32'h60000001);
    rst = 1'b0;
    drive(32'd0, 4'd0);
    #1;
    chk("t6_rst_wren", {63'd0, o_wren}, 64'd0);
    chk("t6_rst_busy", {63'd0, o_busy}, 64'd0);
    chk("t6_rst_addr", {32'd0, o_addr}, 64'd0);
    chk("t6_rst_wdata", {32'd0, o_wdata}, 64'd0);
    chk("t6_rst_done", {63'd0, o_done}, 64'd0);
    chk("t6_rst_ovf", {63'd0, o_overflow}, 64'd0);
    step();
    rst = 1'b1;
    step();
    chk("t6_post_done", {63'd0, o_done}, 64'd0);
    chk("t6_post_busy", {63'd0, o_busy}, 64'd0);
    start_run(32'h0, 32'd0);
    step();
    i_start = 1'b0;
    chk("t6_c0_busy", {63'd0, o_busy}, 64'd1);
    chk("t6_c0_nodone", {63'd0, o_done}, 64'd0);
    step();
    chk("t6_c0_done", {63'd0, o_done}, 64'd1);
    chk("t6_c0_wren", {63'd0, o_wren}, 64'd0);
    step();
    chk("t6_c0_pulse", {63'd0, o_done}, 64'd0);

    // FIFO must be empty after reset: a one-word run writes nothing until fed
    start_run(32'h700, 32'd1);
    step();
    i_start = 1'b0;
    chk("t6_flush1", {63'd0, o_wren}, 64'd0);
    step();
    chk("t6_flush2", {63'd0, o_wren}, 64'd0);
    step();
    chk("t6_flush3", {63'd0, o_wren}, 64'd0);
    drive(32'h77777777, 4'hF); step();
    drive(32'd0, 4'd0);
    step();
    chk_wr("t6_w_new", 32'h700, 32'h77777777);
    step();
    chk("t6_done_new", {63'd0, o_done}, 64'd1);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
